ext_uart_tx: RTL
================

Name: ext_uart_tx

Overview:
- Buffered 8N1 UART transmitter on the core's EXT write port; consumes cq/cwre and drives cbsy back to the core's write-back stage.
- Small FIFO decouples core output bursts from the serial line.
- Core holds cwre only while cbsy is low; this block serialises bytes to txd, LSB first.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per serial bit period; legal range 2..65535.
- FIFO_AW, 2, FIFO address width; depth = 2**FIFO_AW entries (default 4).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- cq  input  8  byte from core, valid when cwre=1.
- cwre  input  1  write strobe, one cycle per byte.
- cbsy  output  1  1 = FIFO full, core must not assert cwre.
- txd  output  1  serial line, idle high.
- tx_active  output  1  1 while a frame is being shifted (state != IDLE); debug/test visibility.

Behaviour:
- Reset (async, active-high): FIFO empty, count=0, rd/wr pointers=0, state=IDLE, baud counter=0, bit index=0, txd=1, cbsy=0, tx_active=0. Reset mid-frame aborts the frame immediately; txd returns high asynchronously.
- Clock and reset: one clock (clk); reset is asynchronous and active-high.
- FIFO:
  - count is FIFO_AW+1 bits wide. cbsy = (count == 2**FIFO_AW), driven from registered count.
  - Push when cwre=1 and count < depth at the sampling edge. cwre while full is dropped silently, with no state change.
  - Pop only on the IDLE->START transition.
  - Simultaneous push and pop: count unchanged, both pointers advance; legal even when full only if push was qualified by count<depth. A full FIFO plus pop on the same edge still drops the write.
  - Pointers wrap modulo depth.
- Output registers: txd and tx_active are registered; txd has no combinational path from the inputs.
- State machine (baud counter counts 0..CLKS_PER_BIT-1; a bit ends when it reaches CLKS_PER_BIT-1):
  - IDLE: txd=1. If count>0: load shift register from FIFO head, pop, clear baud counter, go to START.
  - START: txd=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit, then shift right and increment the index. After bit 7, go to STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles, then go to IDLE.
- IDLE->START re-entry takes one cycle. Back-to-back frames therefore have a stop bit of CLKS_PER_BIT+1 cycles; this is accepted.
- Latency: with cwre sampled at edge N into an empty FIFO and state IDLE, count=1 after N, and txd falls after edge N+1. Frame length is 10*CLKS_PER_BIT cycles plus the 1 IDLE cycle.
- Byte order is FIFO order; no reordering or loss while the core obeys cbsy.
- No parity, no flow control on txd.

Test Plan (bench uses CLKS_PER_BIT=4, FIFO_AW=2):
1. Reset then idle 50 cycles -> txd=1, cbsy=0, tx_active=0 throughout.
2. Single write cq=8'h41 -> txd falls 2 edges after the cwre edge. Sampling mid-bit gives 0,1,0,0,0,0,0,1,0,1 (start, LSB-first 0x41, stop). tx_active stays high for 40 cycles.
3. Burst of 5 consecutive cwre cycles with 0x01..0x05 -> first byte popped immediately, so 4 stored; cbsy rises after the fifth write edge. Next write with cbsy=1 (0xEE) is dropped. Line shows 01,02,03,04,05 only, and cbsy falls when the second frame starts.
4. Full FIFO, cwre asserted on the same edge as the IDLE pop -> write dropped, count goes 4->3. Checker confirms the byte never appears on txd.
5. Assert reset during DATA bit 3 of 0xA5 -> txd=1 and cbsy=0 immediately. After release, no residual bits; a new write 0x5A transmits cleanly.
6. Random core model obeying cbsy, 200 bytes, CLKS_PER_BIT=4 -> UART receiver model decodes an identical sequence with no framing errors.

Source files
------------

// File: rtl/ext_uart_tx_if.sv
// Core EXT write-port handshake: byte, write strobe and back-pressure.
interface ext_uart_tx_if;
  logic [7:0] cq;
  logic       cwre;
  logic       cbsy;

  modport master (output cq, output cwre, input cbsy);
  modport slave  (input cq, input cwre, output cbsy);
endinterface

// File: rtl/ext_uart_tx.sv
// Buffered 8N1 UART transmitter: small FIFO on the core write port, LSB-first
// serialiser to txd with registered line and busy outputs.
module ext_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_AW      = 2
) (
  input  logic          clk,
  input  logic          reset,
  ext_uart_tx_if.slave  core,
  output logic          txd,
  output logic          tx_active
);

  localparam int unsigned DEPTH  = 1 << FIFO_AW;
  localparam int unsigned CNT_W  = FIFO_AW + 1;
  localparam int unsigned BAUD_W = 16;
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                txd_d;

  logic [7:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                cbsy_q;
  logic                push, pop;
  logic                bit_end;

  // A write is only accepted against the registered occupancy, so a pop on the
  // same edge never frees room for it.
  assign push    = core.cwre && (count_q < DEPTH_C);
  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= core.cq;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      cbsy_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      count_q <= count_d;
      cbsy_q  <= (count_d == DEPTH_C);
    end
  end

  assign core.cbsy = cbsy_q;

  // Serialiser next-state; txd is derived from the next state so it registers
  // in step with the state it belongs to.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      txd       <= 1'b1;
      tx_active <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      txd       <= txd_d;
      tx_active <= (state_d != IDLE);
    end
  end

endmodule
